// File: rtl/gba_debug_pkg.sv
// Shared types and constants for the gba_debug_led LED multiplexer.
package gba_debug_pkg;

  typedef enum logic [1:0] {
    DBG_STATIC,
    DBG_SCAN,
    DBG_BUTTONS
  } dbg_mode_e;

  localparam int unsigned DEFAULT_SCAN_DIV = 8388608;

  function automatic int unsigned chunk_count(input int unsigned num_regs,
                                              input int unsigned reg_width,
                                              input int unsigned led_width);
    return (num_regs * reg_width) / led_width;
  endfunction

endpackage

// File: rtl/gba_debug_scan_timer.sv
// Scan prescaler and chunk index counter; held at zero while disabled or restarting.
module gba_debug_scan_timer
  import gba_debug_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = DEFAULT_SCAN_DIV,
  parameter int unsigned NUM_CHUNKS = 16
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       enable,
  input  logic       restart,
  output logic [5:0] scan_idx
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [5:0]    IDX_LAST   = 6'(NUM_CHUNKS - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      presc    <= '0;
      scan_idx <= '0;
    end else if (!enable || restart) begin
      presc    <= '0;
      scan_idx <= '0;
    end else if (presc == PRESC_LAST) begin
      presc    <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 6'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/gba_debug_led.sv
// Debug LED multiplexer: static byte select, auto-scan, button view and snapshot freeze.
// Optional feature: define GBA_DEBUG_SNAPSHOT_EN to build the freeze/snapshot path.
module gba_debug_led
  import gba_debug_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned LED_WIDTH = 8,
  parameter int unsigned SCAN_DIV  = DEFAULT_SCAN_DIV
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [7:0]           sw,
  input  logic [REG_WIDTH-1:0] led_regs [NUM_REGS],
  input  logic [15:0]          buttons,
  input  logic                 freeze,
  output logic [LED_WIDTH-1:0] ld,
  output logic [5:0]           scan_idx
);

  localparam int unsigned NUM_CHUNKS     = chunk_count(NUM_REGS, REG_WIDTH, LED_WIDTH);
  localparam int unsigned NUM_BTN_CHUNKS = 16 / LED_WIDTH;
  localparam int unsigned FLAT_W         = NUM_REGS * REG_WIDTH;

  if ((REG_WIDTH % LED_WIDTH) != 0 || (16 % LED_WIDTH) != 0) begin : g_bad_led_width
    $error("gba_debug_led: LED_WIDTH must divide REG_WIDTH and 16");
  end
  if (NUM_CHUNKS > 64) begin : g_bad_chunks
    $error("gba_debug_led: NUM_CHUNKS exceeds 64");
  end

  dbg_mode_e              mode;
  logic                   scan_q;
  logic [FLAT_W-1:0]      live_flat;
  logic [FLAT_W-1:0]      view_flat;
  logic [15:0]            btn_n;
  logic [LED_WIDTH-1:0]   ld_next;

  assign btn_n = ~buttons;

  always_comb begin
    mode = DBG_STATIC;
    if (sw[7])      mode = DBG_BUTTONS;
    else if (sw[6]) mode = DBG_SCAN;
  end

  always_comb begin
    live_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      live_flat[i*REG_WIDTH +: REG_WIDTH] = led_regs[i];
  end

`ifdef GBA_DEBUG_SNAPSHOT_EN
  logic              freeze_q;
  logic              frozen;
  logic [FLAT_W-1:0] snap_flat;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      freeze_q  <= 1'b0;
      frozen    <= 1'b0;
      snap_flat <= '0;
    end else begin
      freeze_q <= freeze;
      if (freeze && !freeze_q) begin
        snap_flat <= live_flat;
        frozen    <= 1'b1;
      end else if (!freeze && freeze_q) begin
        frozen <= 1'b0;
      end
    end
  end

  assign view_flat = frozen ? snap_flat : live_flat;
`else
  logic unused_freeze;
  assign unused_freeze = freeze;
  assign view_flat     = live_flat;
`endif

  // scan_q remembers last cycle's mode so entry into SCAN restarts the timer
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) scan_q <= 1'b0;
    else        scan_q <= (mode == DBG_SCAN);
  end

  gba_debug_scan_timer #(
    .SCAN_DIV   (SCAN_DIV),
    .NUM_CHUNKS (NUM_CHUNKS)
  ) u_scan_timer (
    .clk      (clk),
    .rst_b    (rst_b),
    .enable   (mode == DBG_SCAN),
    .restart  ((mode == DBG_SCAN) && !scan_q),
    .scan_idx (scan_idx)
  );

  always_comb begin
    ld_next = '0;
    case (mode)
      DBG_BUTTONS: begin
        for (int unsigned k = 0; k < NUM_BTN_CHUNKS; k++)
          if (sw[3:0] == 4'(k)) ld_next = btn_n[k*LED_WIDTH +: LED_WIDTH];
      end
      DBG_SCAN: begin
        for (int unsigned k = 0; k < NUM_CHUNKS; k++)
          if (scan_idx == 6'(k)) ld_next = view_flat[k*LED_WIDTH +: LED_WIDTH];
      end
      default: begin
        for (int unsigned k = 0; k < NUM_CHUNKS; k++)
          if (sw[5:0] == 6'(k)) ld_next = view_flat[k*LED_WIDTH +: LED_WIDTH];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) ld <= '0;
    else        ld <= ld_next;
  end

endmodule

// File: tb/tb_gba_debug_led.sv
// Directed self-checking bench for gba_debug_led (SCAN_DIV shortened to 4).
module tb_gba_debug_led;

  localparam int unsigned NR = 4;
  localparam int unsigned RW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned SD = 4;

`ifdef GBA_DEBUG_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic [7:0]    sw;
  logic [RW-1:0] led_regs [NR];
  logic [15:0]   buttons;
  logic          freeze;
  logic [LW-1:0] ld;
  logic [5:0]    scan_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gba_debug_led #(
    .NUM_REGS  (NR),
    .REG_WIDTH (RW),
    .LED_WIDTH (LW),
    .SCAN_DIV  (SD)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .sw       (sw),
    .led_regs (led_regs),
    .buttons  (buttons),
    .freeze   (freeze),
    .ld       (ld),
    .scan_idx (scan_idx)
  );

  typedef struct {
    logic [7:0]  sw;
    logic [15:0] buttons;
    logic [7:0]  exp_ld;
  } vec_t;

  vec_t vecs [13];

  // regs: 11223344, 55667788, A1B2C3D4, DEADBEEF
  logic [7:0] chunk_exp [16] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                                 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned prev;
    vecs[0]  = '{8'h09, 16'hFFFF, 8'hC3};
    vecs[1]  = '{8'h10, 16'hFFFF, 8'h00};
    vecs[2]  = '{8'h00, 16'hFFFF, 8'h44};
    vecs[3]  = '{8'h0F, 16'hFFFF, 8'hDE};
    vecs[4]  = '{8'h3F, 16'hFFFF, 8'h00};
    vecs[5]  = '{8'h05, 16'hFFFF, 8'h77};
    vecs[6]  = '{8'h80, 16'hFF7E, 8'h81};
    vecs[7]  = '{8'h81, 16'hFF7E, 8'h00};
    vecs[8]  = '{8'h81, 16'h1234, 8'hED};
    vecs[9]  = '{8'h80, 16'h1234, 8'hCB};
    vecs[10] = '{8'h82, 16'h1234, 8'h00};
    vecs[11] = '{8'hC0, 16'h1234, 8'hCB};
    vecs[12] = '{8'h8F, 16'h1234, 8'h00};

    sw      = 8'h00;
    buttons = 16'hFFFF;
    freeze  = 1'b0;
    led_regs[0] = 32'h11223344;
    led_regs[1] = 32'h55667788;
    led_regs[2] = 32'hA1B2C3D4;
    led_regs[3] = 32'hDEADBEEF;

    #12;
    check("reset_ld", 32'(ld), 32'h0);
    check("reset_scan_idx", 32'(scan_idx), 32'h0);
    @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < 13; i++) begin
      sw      = vecs[i].sw;
      buttons = vecs[i].buttons;
      tick();
      check($sformatf("vec%0d_ld", i), 32'(ld), 32'(vecs[i].exp_ld));
    end

    sw = 8'h00;
    tick();
    sw = 8'h40;
    for (int unsigned n = 0; n < 72; n++) begin
      tick();
      prev = (n == 0) ? 0 : ((n - 1) / 4) % 16;
      check($sformatf("scan_idx_n%0d", n), 32'(scan_idx), 32'((n / 4) % 16));
      check($sformatf("scan_ld_n%0d", n), 32'(ld), 32'(chunk_exp[prev]));
    end

    freeze = 1'b1;
    for (int w = 0; w < 200 && scan_idx != 6'd7; w++) tick();
    check("reach_idx7", 32'(scan_idx), 32'd7);
    #2;
    rst_b = 1'b0;
    #1;
    check("async_rst_ld", 32'(ld), 32'h0);
    check("async_rst_idx", 32'(scan_idx), 32'h0);
    freeze = 1'b0;
    tick();
    check("held_rst_idx", 32'(scan_idx), 32'h0);
    rst_b = 1'b1;
    for (int unsigned n = 0; n < 9; n++) begin
      tick();
      prev = (n == 0) ? 0 : ((n - 1) / 4) % 16;
      check($sformatf("rescan_idx_n%0d", n), 32'(scan_idx), 32'((n / 4) % 16));
      check($sformatf("rescan_ld_n%0d", n), 32'(ld), 32'(chunk_exp[prev]));
    end

    sw = 8'h00;
    led_regs[0] = 32'h11;
    tick();
    check("snap_pre", 32'(ld), 32'h11);
    freeze = 1'b1;
    tick();
    check("snap_capture", 32'(ld), 32'h11);
    led_regs[0] = 32'h22;
    tick();
    check("snap_held", 32'(ld), SNAP ? 32'h11 : 32'h22);
    freeze = 1'b0;
    tick();
    check("snap_fall", 32'(ld), SNAP ? 32'h11 : 32'h22);
    tick();
    check("snap_live", 32'(ld), 32'h22);

    sw = 8'h80;
    buttons = 16'hFFFF;
    led_regs[0] = 32'h33;
    tick();
    check("btn_pre", 32'(ld), 32'h00);
    freeze = 1'b1;
    tick();
    check("btn_capture", 32'(ld), 32'h00);
    led_regs[0] = 32'h44;
    sw = 8'h00;
    tick();
    check("btn_snap_used", 32'(ld), SNAP ? 32'h33 : 32'h44);
    freeze = 1'b0;
    tick();
    check("btn_snap_fall", 32'(ld), SNAP ? 32'h33 : 32'h44);
    tick();
    check("btn_snap_live", 32'(ld), 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
